stk_cmd_rsp: RTL and testbench
==============================

# stk_cmd_rsp

Command responder for the stack protocol: accepts one opcode-tagged command per cycle from the engine interconnect, executes PUSH/POP/NOP against a per-engine pointer stack held in flops, and returns exactly one status-bearing response per accepted command. It is the target end of the `stk_pkg` opcode/status interface and sits behind the engine command arbiter. Stack entries are `stk_pkg::ptr_t` (bank id + line id).

## Interface
- `ENGS_N`, default `cfg_pkg::ENGS_N`: number of engines. Engine ids are `stk_pkg::engid_t`.
- `DEPTH_N`, default 16: entries per engine stack. Must be a power of two, at least 2.
- `clk`  in  1  clock; all logic rising-edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_vld`  in  1  command valid.
- `cmd_opcode`  in  `OPCODE_W`  `stk_pkg::opcode_t`.
- `cmd_engid`  in  `ENGID_W`  target engine.
- `cmd_ptr`  in  `PTR_W`  push payload; ignored for other opcodes.
- `cmd_rdy`  out  1  command accepted when `cmd_vld & cmd_rdy`.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response consumed when `rsp_vld & rsp_rdy`.
- `rsp_status`  out  `STATUS_W`  `stk_pkg::response_t`.
- `rsp_engid`  out  `ENGID_W`  echo of the command's engid.
- `rsp_opcode`  out  `OPCODE_W`  echo of the command's opcode.
- `rsp_ptr`  out  `PTR_W`  popped pointer; 0 for all non-OKAY-POP responses.
- `empty_o`  out  `ENGS_N`  per-engine stack empty.
- `full_o`  out  `ENGS_N`  per-engine stack full.

## Operation
- Status codes added to `stk_pkg::response_t` with this block: OKAY=00, UNDERFLOW=01, OVERFLOW=10, INVALID=11.
- State per engine: `cnt[e]`, width `$clog2(DEPTH_N)+1`, range 0..DEPTH_N, and storage `mem[e][0..DEPTH_N-1]`. Storage is not reset.
- PUSH with `cnt<DEPTH_N`: `mem[e][cnt]<=cmd_ptr`, `cnt++`, status OKAY.
- PUSH with `cnt==DEPTH_N`: no write, no count change, status OVERFLOW.
- POP with `cnt>0`: `rsp_ptr=mem[e][cnt-1]`, `cnt--`, status OKAY.
- POP with `cnt==0`: no change, status UNDERFLOW, `rsp_ptr=0`.
- NOP: no change, status OKAY.
- INV opcode, or `cmd_engid>=ENGS_N`: no change, status INVALID.
- All state updates occur on the acceptance edge. The response fields are registered on the same edge.
- Outputs `empty_o[e]=(cnt[e]==0)` and `full_o[e]=(cnt[e]==DEPTH_N)` are combinational from the registered counts.
- Response ordering equals acceptance order. Only one response is buffered.

## Timing
- `cmd_rdy = !rsp_vld | rsp_rdy`. It is combinational from `rsp_rdy`; there is no other dependency.
- Latency is 1 cycle. A command accepted at edge T produces `rsp_vld=1` with its fields valid during cycle T+1.
- Throughput is 1 command per cycle while `rsp_rdy` is held high.
- Response stall: while `rsp_vld & !rsp_rdy`, all `rsp_*` fields hold stable and `cmd_rdy=0`.
- `rsp_vld` falls after a consume edge only if no new command is accepted on that same edge.
- Back-to-back commands to the same engine observe the prior command's update. Example: PUSH at T then POP at T+1 returns the pushed pointer.
- Reset (async, anytime, including with a response pending): `rsp_vld=0`, `rsp_status=OKAY`, `rsp_engid=0`, `rsp_opcode=NOP`, `rsp_ptr=0`, all `cnt=0`. Consequently `empty_o` is all ones, `full_o` is all zeros, and `cmd_rdy=1`. A pending response is dropped.
- The `cmd_*` inputs are sampled only when `cmd_vld & cmd_rdy`. The `rsp_*` outputs are undefined-free (never X) after reset.

## Test plan
- Reset then 3 PUSH to eng 1 (ptrs 0x005, 0x1FF, 0xC00), then 3 POP to eng 1, `rsp_rdy=1` throughout. Required: 6 consecutive responses. The 3 POPs return 0xC00, 0x1FF, 0x005, all OKAY. `empty_o[1]` ends 1.
- POP to empty eng 0 -> UNDERFLOW with `rsp_ptr=0`. Then DEPTH_N+1 PUSH to eng 0 -> the last response is OVERFLOW and `full_o[0]=1`. A following POP returns the DEPTH_N-th pushed ptr.
- INV opcode to eng 2, then NOP to eng 2 -> INVALID then OKAY. Counts are unchanged and `rsp_opcode`/`rsp_engid` echo correctly.
- Backpressure: hold `rsp_rdy=0` for 5 cycles with `cmd_vld=1`. Required: `cmd_rdy=0` for cycles 2-6, the response is stable, and exactly one command is executed. After release, streaming resumes at 1 per cycle.
- Interleave engines: PUSH e0 A, PUSH e1 B, POP e0, POP e1 -> returns A then B, with no cross-engine corruption.
- Assert `arst_n` mid-stream with `rsp_vld=1`. Required: outputs take their reset values immediately, and after release POP to any engine returns UNDERFLOW.

Source files
------------

// File: rtl/stk_cmd_rsp.sv
// Stack command responder: per-engine pointer stacks driven by
// PUSH/POP/NOP commands, one registered response per accepted command.
package cfg_pkg;
   localparam int ENGS_N = 4;
endpackage

package stk_pkg;
   localparam int OPCODE_W = 2;
   localparam int STATUS_W = 2;
   localparam int ENGID_W  = 3;
   localparam int BANK_W   = 4;
   localparam int LINE_W   = 8;
   localparam int PTR_W    = BANK_W + LINE_W;

   typedef enum logic [OPCODE_W-1:0] {
      NOP  = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      INV  = 2'd3
   } opcode_t;

   typedef enum logic [STATUS_W-1:0] {
      OKAY      = 2'b00,
      UNDERFLOW = 2'b01,
      OVERFLOW  = 2'b10,
      INVALID   = 2'b11
   } response_t;

   typedef logic [ENGID_W-1:0] engid_t;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [LINE_W-1:0] line;
   } ptr_t;
endpackage

module stk_cmd_rsp
   import stk_pkg::*;
#(
   parameter int ENGS_N  = cfg_pkg::ENGS_N,
   parameter int DEPTH_N = 16
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                cmd_vld,
   input  logic [OPCODE_W-1:0] cmd_opcode,
   input  logic [ENGID_W-1:0]  cmd_engid,
   input  logic [PTR_W-1:0]    cmd_ptr,
   output logic                cmd_rdy,
   output logic                rsp_vld,
   input  logic                rsp_rdy,
   output logic [STATUS_W-1:0] rsp_status,
   output logic [ENGID_W-1:0]  rsp_engid,
   output logic [OPCODE_W-1:0] rsp_opcode,
   output logic [PTR_W-1:0]    rsp_ptr,
   output logic [ENGS_N-1:0]   empty_o,
   output logic [ENGS_N-1:0]   full_o
);
   localparam int AW = $clog2(DEPTH_N);
   localparam int CW = AW + 1;
   localparam int SW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH_N);

   logic [CW-1:0] cnt [ENGS_N];
   ptr_t          mem [ENGS_N][DEPTH_N];

   logic          acc;
   logic          inv;
   logic          do_push;
   logic          do_pop;
   logic [SW-1:0] sel;
   logic [CW-1:0] cur;
   response_t     st;
   ptr_t          pop_ptr;

   assign cmd_rdy = !rsp_vld || rsp_rdy;
   assign acc     = cmd_vld && cmd_rdy;

   always_comb begin
      sel     = cmd_engid[SW-1:0];
      cur     = cnt[sel];
      pop_ptr = mem[sel][AW'(cur - 1'b1)];
      inv     = (int'(cmd_engid) >= ENGS_N) || (cmd_opcode == INV);
      do_push = 1'b0;
      do_pop  = 1'b0;
      st      = OKAY;
      unique case (1'b1)
         inv: st = INVALID;
         !inv && cmd_opcode == PUSH: begin
            if (cur == FULL) st = OVERFLOW;
            else do_push = 1'b1;
         end
         !inv && cmd_opcode == POP: begin
            if (cur == '0) st = UNDERFLOW;
            else do_pop = 1'b1;
         end
         default: st = OKAY;
      endcase
   end

   // Stack storage is deliberately left unreset; cnt alone defines validity.
   always_ff @(posedge clk) begin
      if (acc && do_push) mem[sel][cur[AW-1:0]] <= cmd_ptr;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int e = 0; e < ENGS_N; e++) cnt[e] <= '0;
      end else if (acc) begin
         if (do_push) cnt[sel] <= cur + 1'b1;
         else if (do_pop) cnt[sel] <= cur - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rsp_vld    <= 1'b0;
         rsp_status <= OKAY;
         rsp_engid  <= '0;
         rsp_opcode <= NOP;
         rsp_ptr    <= '0;
      end else if (acc) begin
         rsp_vld    <= 1'b1;
         rsp_status <= st;
         rsp_engid  <= cmd_engid;
         rsp_opcode <= cmd_opcode;
         rsp_ptr    <= do_pop ? pop_ptr : '0;
      end else if (rsp_rdy) begin
         rsp_vld    <= 1'b0;
      end
   end

   for (genvar e = 0; e < ENGS_N; e++) begin : g_flag
      assign empty_o[e] = (cnt[e] == '0);
      assign full_o[e]  = (cnt[e] == FULL);
   end
endmodule

// File: tb/tb_stk_cmd_rsp.sv
// Bench for stk_cmd_rsp: queue-based stack model checked every cycle,
// plus hand-computed expectations on selected responses.
module tb_stk_cmd_rsp;
   localparam int ENGS  = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        cmd_vld = 1'b0;
   logic [1:0]  cmd_opcode = 2'd0;
   logic [2:0]  cmd_engid = 3'd0;
   logic [11:0] cmd_ptr = 12'd0;
   logic        cmd_rdy;
   logic        rsp_vld;
   logic        rsp_rdy = 1'b1;
   logic [1:0]  rsp_status;
   logic [2:0]  rsp_engid;
   logic [1:0]  rsp_opcode;
   logic [11:0] rsp_ptr;
   logic [3:0]  empty_o;
   logic [3:0]  full_o;

   stk_cmd_rsp dut (
      .clk(clk), .arst_n(arst_n),
      .cmd_vld(cmd_vld), .cmd_opcode(cmd_opcode),
      .cmd_engid(cmd_engid), .cmd_ptr(cmd_ptr),
      .cmd_rdy(cmd_rdy), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
      .rsp_status(rsp_status), .rsp_engid(rsp_engid),
      .rsp_opcode(rsp_opcode), .rsp_ptr(rsp_ptr),
      .empty_o(empty_o), .full_o(full_o)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1;
   localparam logic [1:0] POP = 2'd2, INV = 2'd3;
   localparam logic [1:0] OK = 2'd0, UNF = 2'd1;
   localparam logic [1:0] OVF = 2'd2, BAD = 2'd3;

   typedef struct packed {
      logic [1:0]  st;
      logic [2:0]  eng;
      logic [1:0]  op;
      logic [11:0] ptr;
   } rsp_t;

   int total = 0;
   int bad = 0;

   logic [11:0] stk [ENGS][$];
   logic        ev = 1'b0;
   logic [1:0]  es = 2'd0;
   logic [2:0]  ee = 3'd0;
   logic [1:0]  eo = 2'd0;
   logic [11:0] ep = 12'd0;
   rsp_t        log_q [$];

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, x, $time);
      end
   endtask

   // Model: stacks as queues, one pending response slot.
   initial forever begin
      int e;
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
         for (int i = 0; i < ENGS; i++) stk[i].delete();
         ev = 0; es = OK; ee = 0; eo = NOP; ep = 0;
      end else if (cmd_vld && (!ev || rsp_rdy)) begin
         e = int'(cmd_engid);
         ev = 1; ee = cmd_engid; eo = cmd_opcode; ep = 0; es = OK;
         if (e >= ENGS || cmd_opcode == INV) es = BAD;
         else if (cmd_opcode == PUSH) begin
            if (stk[e].size() == DEPTH) es = OVF;
            else stk[e].push_back(cmd_ptr);
         end else if (cmd_opcode == POP) begin
            if (stk[e].size() == 0) es = UNF;
            else ep = stk[e].pop_back();
         end
      end else if (rsp_rdy) begin
         ev = 0;
      end
   end

   initial forever begin
      logic [3:0] xe, xf;
      @(negedge clk);
      for (int i = 0; i < ENGS; i++) begin
         xe[i] = (stk[i].size() == 0);
         xf[i] = (stk[i].size() == DEPTH);
      end
      chk("cmd_rdy", 32'(cmd_rdy), 32'(!ev || rsp_rdy));
      chk("rsp_vld", 32'(rsp_vld), 32'(ev));
      chk("empty_o", 32'(empty_o), 32'(xe));
      chk("full_o", 32'(full_o), 32'(xf));
      if (ev) begin
         chk("rsp_status", 32'(rsp_status), 32'(es));
         chk("rsp_engid", 32'(rsp_engid), 32'(ee));
         chk("rsp_opcode", 32'(rsp_opcode), 32'(eo));
         chk("rsp_ptr", 32'(rsp_ptr), 32'(ep));
      end
      if (rsp_vld && rsp_rdy && arst_n)
         log_q.push_back({rsp_status, rsp_engid, rsp_opcode, rsp_ptr});
   end

   task automatic send(input logic [1:0] op, input logic [2:0] e,
                       input logic [11:0] p);
      int n = 0;
      cmd_vld = 1'b1; cmd_opcode = op; cmd_engid = e; cmd_ptr = p;
      while (!cmd_rdy && n < 20) begin
         @(posedge clk); #2; n++;
      end
      if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
      @(posedge clk); #2;
      cmd_vld = 1'b0;
   endtask

   task automatic wait_log(input int want);
      int n = 0;
      while (log_q.size() < want && n < 50) begin
         @(posedge clk); #2; n++;
      end
      chk("log_wait", 32'(log_q.size() >= want), 32'd1);
   endtask

   task automatic chk_rsp(input string n, input int idx,
                          input logic [1:0] st, input logic [11:0] p);
      if (idx < log_q.size()) begin
         chk({n, "_st"}, 32'(log_q[idx].st), 32'(st));
         chk({n, "_ptr"}, 32'(log_q[idx].ptr), 32'(p));
      end else chk({n, "_missing"}, 32'(idx), 32'(log_q.size()));
   endtask

   initial begin
      int b;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 32'(cmd_rdy), 32'd1);
      chk("rst_empty", 32'(empty_o), 32'hF);
      chk("rst_vld", 32'(rsp_vld), 32'd0);
      #1 arst_n = 1'b1;
      @(posedge clk); #2;

      // LIFO order on engine 1
      b = log_q.size();
      send(PUSH, 3'd1, 12'h005);
      send(PUSH, 3'd1, 12'h1FF);
      send(PUSH, 3'd1, 12'hC00);
      send(POP, 3'd1, 12'h000);
      send(POP, 3'd1, 12'h000);
      send(POP, 3'd1, 12'h000);
      wait_log(b + 6);
      chk_rsp("e1_push", b, OK, 12'h000);
      chk_rsp("e1_pop0", b + 3, OK, 12'hC00);
      chk_rsp("e1_pop1", b + 4, OK, 12'h1FF);
      chk_rsp("e1_pop2", b + 5, OK, 12'h005);
      chk("e1_empty", 32'(empty_o[1]), 32'd1);

      // Underflow, fill to overflow, pop the last stored pointer
      b = log_q.size();
      send(POP, 3'd0, 12'hFFF);
      for (int i = 0; i < DEPTH + 1; i++) send(PUSH, 3'd0, 12'h100 + 12'(i));
      wait_log(b + DEPTH + 2);
      chk_rsp("e0_unf", b, UNF, 12'h000);
      chk_rsp("e0_last_ok", b + DEPTH, OK, 12'h000);
      chk_rsp("e0_ovf", b + DEPTH + 1, OVF, 12'h000);
      chk("e0_full", 32'(full_o[0]), 32'd1);
      b = log_q.size();
      send(POP, 3'd0, 12'h000);
      wait_log(b + 1);
      chk_rsp("e0_pop_top", b, OK, 12'h10F);

      // Invalid opcode / engine id and NOP
      b = log_q.size();
      send(INV, 3'd2, 12'h123);
      send(NOP, 3'd2, 12'h456);
      send(PUSH, 3'd5, 12'h789);
      wait_log(b + 3);
      chk_rsp("inv_op", b, BAD, 12'h000);
      chk_rsp("nop", b + 1, OK, 12'h000);
      chk_rsp("inv_eng", b + 2, BAD, 12'h000);
      if (b + 1 < log_q.size()) begin
         chk("inv_echo_op", 32'(log_q[b].op), 32'(INV));
         chk("nop_echo_eng", 32'(log_q[b + 1].eng), 32'd2);
      end
      chk("e2_empty", 32'(empty_o[2]), 32'd1);

      // Backpressure: one command stalls for 5 cycles
      b = log_q.size();
      send(PUSH, 3'd3, 12'h0AA);
      rsp_rdy = 1'b0;
      cmd_vld = 1'b1; cmd_opcode = PUSH;
      cmd_engid = 3'd3; cmd_ptr = 12'h0BB;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         chk("bp_rdy", 32'(cmd_rdy), 32'd0);
         chk("bp_hold_op", 32'(rsp_opcode), 32'(PUSH));
         chk("bp_hold_vld", 32'(rsp_vld), 32'd1);
      end
      rsp_rdy = 1'b1;
      @(posedge clk); #2;
      cmd_vld = 1'b0;
      send(POP, 3'd3, 12'h000);
      send(POP, 3'd3, 12'h000);
      send(POP, 3'd3, 12'h000);
      wait_log(b + 5);
      chk_rsp("bp_pop0", b + 2, OK, 12'h0BB);
      chk_rsp("bp_pop1", b + 3, OK, 12'h0AA);
      chk_rsp("bp_pop2", b + 4, UNF, 12'h000);

      // Interleaved engines
      b = log_q.size();
      send(PUSH, 3'd0, 12'hA0A);
      send(PUSH, 3'd1, 12'hB0B);
      send(POP, 3'd0, 12'h000);
      send(POP, 3'd1, 12'h000);
      wait_log(b + 4);
      chk_rsp("il_e0", b + 2, OK, 12'hA0A);
      chk_rsp("il_e1", b + 3, OK, 12'hB0B);

      // Asynchronous reset with a response pending
      send(PUSH, 3'd2, 12'h222);
      chk("pre_rst_vld", 32'(rsp_vld), 32'd1);
      arst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(rsp_vld), 32'd0);
      chk("arst_rdy", 32'(cmd_rdy), 32'd1);
      chk("arst_empty", 32'(empty_o), 32'hF);
      chk("arst_full", 32'(full_o), 32'h0);
      chk("arst_fields",
          32'({rsp_status, rsp_engid, rsp_opcode, rsp_ptr}), 32'd0);
      @(posedge clk); #2;
      arst_n = 1'b1;
      @(posedge clk); #2;
      b = log_q.size();
      for (int i = 0; i < ENGS; i++) send(POP, 3'(i), 12'h000);
      wait_log(b + ENGS);
      for (int i = 0; i < ENGS; i++)
         chk_rsp("post_rst_unf", b + i, UNF, 12'h000);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
